// File: rtl/fetch_unit.sv
// PC / instruction-register stage of the 8-bit multicycle datapath: byte-serial
// instruction assembly, MDR capture, memory address mux and field decode.

module fetch_ir_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] byte_q,
  output logic       vld_q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (we) byte_q <= din;
      // clear by a PC update first, then mark the lane written this cycle
      vld_q <= (clr ? 1'b0 : vld_q) | we;
    end
  end
endmodule

module fetch_unit #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic [1:0]       pcsource,
  input  logic             iord,
  input  logic [3:0]       iwrite,
  input  logic [WIDTH-1:0] memdata,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [WIDTH-1:0] mdr,
  output logic             instr_valid
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] ir_q;
  logic [NUM_LANES-1:0]            mask;
  logic [WIDTH-1:0]                pc_nxt;
  logic [WIDTH-1:0]                jmp_tgt;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      fetch_ir_lane u_lane (
        .clk    (clk),
        .reset  (reset),
        .we     (iwrite[g]),
        .clr    (pcen),
        .din    (memdata[VEC_W-1:0]),
        .byte_q (ir_q[g]),
        .vld_q  (mask[g])
      );
    end
  endgenerate

  assign jmp_tgt = {instr[WIDTH-3:0], 2'b00};

  always_comb begin
    pc_nxt = pc;
    case (pcsource)
      2'b00:   pc_nxt = aluresult;
      2'b01:   pc_nxt = aluout;
      2'b10:   pc_nxt = jmp_tgt;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      mdr <= '0;
    end else begin
      if (pcen) pc <= pc_nxt;
      mdr <= memdata;
    end
  end

  assign adr         = iord ? aluout : pc;
  assign instr       = ir_q;
  assign instr_valid = &mask;
  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm         = instr[15:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, byte assembly, valid mask, PC muxing,
// address mux, MDR and asynchronous reset mid-fetch.

module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       pcen;
  logic [1:0] pcsource;
  logic       iord;
  logic [3:0] iwrite;
  logic [7:0] memdata, aluresult, aluout;
  logic [7:0] adr, pc, mdr;
  logic [31:0] instr;
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic       instr_valid;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .pcsource(pcsource), .iord(iord),
    .iwrite(iwrite), .memdata(memdata), .aluresult(aluresult), .aluout(aluout),
    .adr(adr), .pc(pc), .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .mdr(mdr), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one clock with the given controls; inputs change 1ns after the edge
  task automatic cyc(input logic pe, input logic [1:0] ps, input logic [3:0] iw,
                     input logic [7:0] md, input logic [7:0] ar);
    pcen = pe; pcsource = ps; iwrite = iw; memdata = md; aluresult = ar;
    step();
  endtask

  initial begin
    reset = 1'b0; pcen = 0; pcsource = 2'b11; iord = 0; iwrite = 0;
    memdata = 0; aluresult = 0; aluout = 0;
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fields", {op, rs, rt, rd, imm}, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_pc", pc, 0);
      chk("idle_instr", instr, 0);
      chk("idle_mdr", mdr, 0);
      chk("idle_valid", instr_valid, 0);
      chk("idle_adr", adr, 0);
    end

    // fetch with pcen every cycle: mask never fills
    cyc(1, 2'b00, 4'b0001, 8'h20, 8'd1); chk("f1_valid", instr_valid, 0);
    cyc(1, 2'b00, 4'b0010, 8'h05, 8'd2); chk("f2_valid", instr_valid, 0);
    cyc(1, 2'b00, 4'b0100, 8'h0A, 8'd3); chk("f3_valid", instr_valid, 0);
    cyc(1, 2'b00, 4'b1000, 8'h8C, 8'd4);
    chk("f_instr", instr, 32'h8C0A0520);
    chk("f_op", op, 6'h23);
    chk("f_rs", rs, 0);
    chk("f_rt", rt, 10);
    chk("f_rd", rd, 0);
    chk("f_imm", imm, 16'h0520);
    chk("f_pc", pc, 4);
    chk("f_valid", instr_valid, 0);
    chk("f_mdr", mdr, 8'h8C);

    // clear mask, then load the same bytes with pcen=0
    cyc(1, 2'b11, 4'b0000, 8'h00, 8'd0); chk("hold_pc", pc, 4);
    cyc(0, 2'b00, 4'b0001, 8'h20, 8'd9); chk("l1_valid", instr_valid, 0);
    cyc(0, 2'b00, 4'b0010, 8'h05, 8'd9); chk("l2_valid", instr_valid, 0);
    cyc(0, 2'b00, 4'b0100, 8'h0A, 8'd9); chk("l3_valid", instr_valid, 0);
    cyc(0, 2'b00, 4'b1000, 8'h8C, 8'd9); chk("l4_valid", instr_valid, 1);
    chk("l4_pc_held", pc, 4);
    cyc(0, 2'b00, 4'b0001, 8'h20, 8'd9); chk("rewrite_valid", instr_valid, 1);
    chk("rewrite_instr", instr, 32'h8C0A0520);
    cyc(1, 2'b11, 4'b0000, 8'h00, 8'd0); chk("clr_valid", instr_valid, 0);

    // pcen and iwrite together: clear first, then new lanes marked
    cyc(1, 2'b11, 4'b0011, 8'h0F, 8'd0); chk("pw_valid", instr_valid, 0);
    cyc(0, 2'b11, 4'b1100, 8'h0F, 8'd0); chk("pw_valid2", instr_valid, 1);
    chk("multi_instr", instr, 32'h0F0F0F0F);

    // jump, hold, wrap, aluout source, pcen=0 hold
    cyc(1, 2'b10, 4'b0000, 8'h00, 8'd0); chk("jmp_pc", pc, 8'h3C);
    cyc(1, 2'b11, 4'b0000, 8'h00, 8'd0); chk("ps11_pc", pc, 8'h3C);
    cyc(1, 2'b00, 4'b0000, 8'h00, 8'hFF); chk("ff_pc", pc, 8'hFF);
    cyc(1, 2'b00, 4'b0000, 8'h00, 8'h00); chk("wrap_pc", pc, 8'h00);
    aluout = 8'h10;
    cyc(1, 2'b01, 4'b0000, 8'h00, 8'h77); chk("aluout_pc", pc, 8'h10);
    cyc(0, 2'b00, 4'b0000, 8'h00, 8'h55); chk("nopcen_pc", pc, 8'h10);

    // address mux is combinational
    aluout = 8'h44; iord = 1; #1;
    chk("adr_iord1", adr, 8'h44);
    iord = 0; #1;
    chk("adr_iord0", adr, 8'h10);
    memdata = 8'hA5; #1;
    chk("mdr_pre", mdr, 8'h00);
    step();
    chk("mdr_a5", mdr, 8'hA5);

    // async reset in the middle of a partial fetch
    cyc(1, 2'b11, 4'b0000, 8'h00, 8'd0);
    cyc(0, 2'b11, 4'b0001, 8'h11, 8'd0);
    cyc(0, 2'b11, 4'b0010, 8'h22, 8'd0);
    chk("pre_rst_instr", instr, 32'h0F0F2211);
    iwrite = 0; #2;
    reset = 1'b0; #1;
    chk("arst_pc", pc, 0);
    chk("arst_instr", instr, 0);
    chk("arst_valid", instr_valid, 0);
    #1 reset = 1'b1;
    cyc(0, 2'b11, 4'b0100, 8'h33, 8'd0); chk("r3_valid", instr_valid, 0);
    cyc(0, 2'b11, 4'b1000, 8'h44, 8'd0); chk("r4_valid", instr_valid, 0);
    cyc(0, 2'b11, 4'b0001, 8'h11, 8'd0); chk("r1_valid", instr_valid, 0);
    cyc(0, 2'b11, 4'b0010, 8'h22, 8'd0); chk("r2_valid", instr_valid, 1);
    chk("r_instr", instr, 32'h44332211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
